// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: width default, FSM state
// encodings, access-size decode and alignment helpers.
package mem_stage_pkg;

  localparam int DEF_XLEN = 64;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  // Access size carried in funct3[1:0]; funct3[2] selects zero-extension.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  function automatic size_e f3_size(input logic [2:0] funct3);
    return size_e'(funct3[1:0]);
  endfunction

  function automatic logic f3_is_unsigned(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  // Byte-enable pattern for an access of the given size at lane 0.
  function automatic logic [7:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // True when the low address bits do not match the natural alignment.
  function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus: req/gnt address phase, rvalid response.
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] be;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: pick the addressed bytes out of the aligned
// doubleword and sign- or zero-extend them to XLEN.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;
  logic            ext_bit_b;
  logic            ext_bit_h;
  logic            ext_bit_w;

  assign shifted   = rdata >> {offset, 3'b000};
  assign ext_bit_b = ~f3_is_unsigned(funct3) & shifted[7];
  assign ext_bit_h = ~f3_is_unsigned(funct3) & shifted[15];
  assign ext_bit_w = ~f3_is_unsigned(funct3) & shifted[31];

  // Extend the low bytes of the shifted doubleword according to access size.
  always_comb begin
    data = shifted;
    case (f3_size(funct3))
      SZ_B:    data = {{(XLEN-8){ext_bit_b}}, shifted[7:0]};
      SZ_H:    data = {{(XLEN-16){ext_bit_h}}, shifted[15:0]};
      SZ_W:    data = {{(XLEN-32){ext_bit_w}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory transaction per load/store,
// stalls upstream while it is outstanding, and registers the MEM/WB result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              em_valid,
  input  logic              em_memRead,
  input  logic              em_memWrite,
  input  logic              em_memToReg,
  input  logic              em_regWrite,
  input  logic [4:0]        em_rd,
  input  logic [2:0]        em_funct3,
  input  logic [XLEN-1:0]   em_aluRes,
  input  logic [XLEN-1:0]   em_storeData,
  mem_stage_if.master       dmem,
  output logic              mw_valid,
  output logic              mw_regWrite,
  output logic [4:0]        mw_rd,
  output logic [XLEN-1:0]   mw_rdOut,
  output logic              mw_exc,
  output logic              mem_stall
);

  state_t          state_reg, state_next;
  logic [15:0]     timer_reg, timer_next;
  logic            timeout_hit;

  // Transaction captured at launch; upstream is frozen but this keeps the
  // request stable independent of the EX/MEM register.
  logic            t_we_reg;
  logic [XLEN-1:0] t_alu_reg;
  logic [XLEN-1:0] t_wdata_reg;
  logic [7:0]      t_be_reg;
  logic [2:0]      t_funct3_reg;
  logic [4:0]      t_rd_reg;
  logic            t_regwrite_reg;
  logic            t_memtoreg_reg;

  logic            mw_valid_reg;
  logic            mw_regwrite_reg;
  logic [4:0]      mw_rd_reg;
  logic [XLEN-1:0] mw_rdout_reg;
  logic            mw_exc_reg;

  // Decode of the instruction currently in EX/MEM
  size_e           em_size;
  logic [2:0]      em_off;
  logic            em_mem_op;
  logic            em_misaligned;
  logic [7:0]      em_be;
  logic [XLEN-1:0] em_wdata;

  assign em_size       = f3_size(em_funct3);
  assign em_off        = em_aluRes[2:0];
  assign em_mem_op     = em_memRead | em_memWrite;
  assign em_misaligned = is_misaligned(em_size, em_off);
  assign em_be         = size_mask(em_size) << em_off;
  assign em_wdata      = em_storeData << {em_off, 3'b000};

  // The watchdog fires on the cycle the REQ+WAIT count reaches TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (timer_reg == 16'(TIMEOUT - 1));

  // Retirement source: live EX/MEM fields in IDLE, captured fields otherwise.
  logic            r_is_load;
  logic            r_is_store;
  logic            r_memtoreg;
  logic            r_regwrite;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] load_data;

  // Select the instruction whose result is being retired this cycle.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      r_is_load  = em_memRead;
      r_is_store = em_memWrite;
      r_memtoreg = em_memToReg;
      r_regwrite = em_regWrite;
      r_rd       = em_rd;
      r_alu      = em_aluRes;
      r_funct3   = em_funct3;
    end else begin
      r_is_load  = ~t_we_reg;
      r_is_store = t_we_reg;
      r_memtoreg = t_memtoreg_reg;
      r_regwrite = t_regwrite_reg;
      r_rd       = t_rd_reg;
      r_alu      = t_alu_reg;
      r_funct3   = t_funct3_reg;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem.rdata),
    .offset (r_alu[2:0]),
    .funct3 (r_funct3),
    .data   (load_data)
  );

  logic            req_c;
  logic            we_c;
  logic [XLEN-1:0] addr_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      be_c;
  logic            stall_c;
  logic            launch;
  logic            retire;
  logic            retire_exc;

  // Next-state, request drive, stall and retirement decisions.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    be_c       = '0;
    stall_c    = 1'b0;
    launch     = 1'b0;
    retire     = 1'b0;
    retire_exc = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (em_valid) begin
          if (!em_mem_op) begin
            retire = 1'b1;
          end else if (em_misaligned) begin
            retire     = 1'b1;
            retire_exc = 1'b1;
          end else begin
            launch  = 1'b1;
            req_c   = 1'b1;
            we_c    = em_memWrite;
            addr_c  = {em_aluRes[XLEN-1:3], 3'b000};
            wdata_c = em_wdata;
            be_c    = em_be;
            if (dmem.gnt && dmem.rvalid) begin
              retire = 1'b1;
            end else begin
              stall_c    = 1'b1;
              timer_next = '0;
              state_next = dmem.gnt ? ST_WAIT : ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (timeout_hit) begin
          retire     = 1'b1;
          retire_exc = 1'b1;
          state_next = ST_IDLE;
        end else begin
          req_c   = 1'b1;
          we_c    = t_we_reg;
          addr_c  = {t_alu_reg[XLEN-1:3], 3'b000};
          wdata_c = t_wdata_reg;
          be_c    = t_be_reg;
          if (dmem.gnt && dmem.rvalid) begin
            retire     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stall_c    = 1'b1;
            timer_next = timer_reg + 16'd1;
            if (dmem.gnt) state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem.rvalid) begin
          retire     = 1'b1;
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          retire     = 1'b1;
          retire_exc = 1'b1;
          state_next = ST_IDLE;
        end else begin
          stall_c    = 1'b1;
          timer_next = timer_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (rst) begin
      req_c   = 1'b0;
      stall_c = 1'b0;
    end
  end

  assign dmem.req   = req_c;
  assign dmem.we    = req_c & we_c;
  assign dmem.addr  = req_c ? addr_c  : '0;
  assign dmem.wdata = req_c ? wdata_c : '0;
  assign dmem.be    = req_c ? be_c    : '0;
  assign mem_stall  = stall_c;

  // State, watchdog, transaction capture and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      timer_reg       <= '0;
      t_we_reg        <= 1'b0;
      t_alu_reg       <= '0;
      t_wdata_reg     <= '0;
      t_be_reg        <= '0;
      t_funct3_reg    <= '0;
      t_rd_reg        <= '0;
      t_regwrite_reg  <= 1'b0;
      t_memtoreg_reg  <= 1'b0;
      mw_valid_reg    <= 1'b0;
      mw_regwrite_reg <= 1'b0;
      mw_rd_reg       <= '0;
      mw_rdout_reg    <= '0;
      mw_exc_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      mw_valid_reg <= retire;
      if (launch) begin
        t_we_reg       <= em_memWrite;
        t_alu_reg      <= em_aluRes;
        t_wdata_reg    <= em_wdata;
        t_be_reg       <= em_be;
        t_funct3_reg   <= em_funct3;
        t_rd_reg       <= em_rd;
        t_regwrite_reg <= em_regWrite;
        t_memtoreg_reg <= em_memToReg;
      end
      if (retire) begin
        mw_rd_reg       <= r_rd;
        mw_exc_reg      <= retire_exc;
        mw_regwrite_reg <= r_regwrite & ~r_is_store & ~retire_exc;
        mw_rdout_reg    <= (r_is_load && r_memtoreg && !retire_exc) ? load_data : r_alu;
      end
    end
  end

  assign mw_valid    = mw_valid_reg;
  assign mw_regWrite = mw_regwrite_reg;
  assign mw_rd       = mw_rd_reg;
  assign mw_rdOut    = mw_rdout_reg;
  assign mw_exc      = mw_exc_reg;

endmodule
